// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter sequencer: FSM states,
// next-PC select codes and the default sequential step.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_HALT   = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2
  } pc_sel_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC calculation: link value, branch target, jump target
// and the jump > taken-branch > sequential priority select.
module pc_target_calc
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] STEP = 32'd4
) (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        bne,
  input  logic        eq,
  input  logic        jump,
  input  logic [31:0] imm,
  input  logic [25:0] jump_idx,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        br_taken;
  pc_sel_e     sel;

  // Candidate targets; all adds wrap modulo 2^32 with no flag.
  always_comb begin
    pc_plus4   = pc + STEP;
    br_target  = pc_plus4 + (imm << 2);
    jmp_target = {pc_plus4[31:28], jump_idx, 2'b00};
    br_taken   = branch & (eq ^ bne);
  end

  // Priority select: jump beats a taken branch, which beats sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (jump) begin
      sel = SEL_JMP;
    end else if (br_taken) begin
      sel = SEL_BR;
    end
    case (sel)
      SEL_JMP: next_pc = jmp_target;
      SEL_BR:  next_pc = br_target;
      default: next_pc = pc_plus4;
    endcase
    redirect = (sel != SEL_SEQ);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches each instruction over a req/ack
// handshake, then resolves beq/bne/jump in COMMIT and updates the PC.
// Optional feature macro: BRANCH_STATS_EN builds saturating counters of
// resolved and taken branches; without it outBrTotal/outBrTaken read 0.
//
//  state  | meaning
//  IDLE   | one cycle after reset release, no request yet
//  REQ    | outFetchReq high, waiting for inFetchAck
//  COMMIT | instruction valid; resolve next PC unless stalled
//  HALT   | sequencing stopped until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter int          STAT_W   = 16
) (
  input  logic              inClk,
  input  logic              inRstN,
  output logic              outFetchReq,
  input  logic              inFetchAck,
  input  logic              inStall,
  input  logic              inHalt,
  input  logic              inBranch,
  input  logic              inBne,
  input  logic              inEq,
  input  logic              inJump,
  input  logic [31:0]       inImm,
  input  logic [25:0]       inJumpIdx,
  output logic [31:0]       outPC,
  output logic [31:0]       outPCPlus4,
  output logic              outTaken,
  output logic              outHalted,
  output logic [STAT_W-1:0] outBrTotal,
  output logic [STAT_W-1:0] outBrTaken
);
  import pc_unit_pkg::*;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_req_q, fetch_req_d;
  logic        taken_q, taken_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        commit_go;

  pc_target_calc #(.STEP(PC_STEP)) u_target (
    .pc       (pc_q),
    .branch   (inBranch),
    .bne      (inBne),
    .eq       (inEq),
    .jump     (inJump),
    .imm      (inImm),
    .jump_idx (inJumpIdx),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc),
    .redirect (redirect)
  );

  assign commit_go = (state_q == ST_COMMIT) && !inStall;

  // Next state, next PC and the registered versions of the status outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (inFetchAck) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (commit_go) begin
          pc_d    = next_pc;
          taken_d = redirect;
          state_d = inHalt ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    fetch_req_d = (state_d == ST_REQ);
    halted_d    = (state_d == ST_HALT);
  end

  // FSM, PC and registered outputs; reset aborts any fetch or commit.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      taken_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      taken_q     <= taken_d;
      halted_q    <= halted_d;
    end
  end

  assign outPC       = pc_q;
  assign outPCPlus4  = pc_plus4;
  assign outFetchReq = fetch_req_q;
  assign outTaken    = taken_q;
  assign outHalted   = halted_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] br_total_q, br_total_d;
  logic [STAT_W-1:0] br_taken_q, br_taken_d;
  logic              br_cond_taken;

  // Count every resolved conditional branch, saturating at all-ones.
  always_comb begin
    br_total_d    = br_total_q;
    br_taken_d    = br_taken_q;
    br_cond_taken = inBranch & (inEq ^ inBne);
    if (commit_go && inBranch) begin
      if (br_total_q != '1) br_total_d = br_total_q + 1'b1;
      if (br_cond_taken && (br_taken_q != '1)) br_taken_d = br_taken_q + 1'b1;
    end
  end

  // Statistic registers.
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign outBrTotal = br_total_q;
  assign outBrTaken = br_taken_q;
`else
  assign outBrTotal = '0;
  assign outBrTaken = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer with a transaction-level
// reference model of the fetch/commit sequence and PC arithmetic.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          STAT_W   = 16;

  localparam int MD_IDLE   = 0;
  localparam int MD_FETCH  = 1;
  localparam int MD_EXEC   = 2;
  localparam int MD_HALTED = 3;

  logic              inClk;
  logic              inRstN;
  logic              outFetchReq;
  logic              inFetchAck;
  logic              inStall;
  logic              inHalt;
  logic              inBranch;
  logic              inBne;
  logic              inEq;
  logic              inJump;
  logic [31:0]       inImm;
  logic [25:0]       inJumpIdx;
  logic [31:0]       outPC;
  logic [31:0]       outPCPlus4;
  logic              outTaken;
  logic              outHalted;
  logic [STAT_W-1:0] outBrTotal;
  logic [STAT_W-1:0] outBrTaken;

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (32'd4),
    .STAT_W   (STAT_W)
  ) dut (
    .inClk       (inClk),
    .inRstN      (inRstN),
    .outFetchReq (outFetchReq),
    .inFetchAck  (inFetchAck),
    .inStall     (inStall),
    .inHalt      (inHalt),
    .inBranch    (inBranch),
    .inBne       (inBne),
    .inEq        (inEq),
    .inJump      (inJump),
    .inImm       (inImm),
    .inJumpIdx   (inJumpIdx),
    .outPC       (outPC),
    .outPCPlus4  (outPCPlus4),
    .outTaken    (outTaken),
    .outHalted   (outHalted),
    .outBrTotal  (outBrTotal),
    .outBrTaken  (outBrTaken)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  int checks = 0;
  int errors = 0;

  // Reference model
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_taken;
  logic [15:0] m_tot;
  logic [15:0] m_tkn;

  task automatic model_reset();
    m_mode  = MD_IDLE;
    m_pc    = RESET_PC;
    m_taken = 1'b0;
    m_tot   = '0;
    m_tkn   = '0;
  endtask

  task automatic model_step();
    logic [31:0] plus4;
    logic        br_tk;
    m_taken = 1'b0;
    case (m_mode)
      MD_IDLE:  m_mode = MD_FETCH;
      MD_FETCH: if (inFetchAck) m_mode = MD_EXEC;
      MD_EXEC: begin
        if (!inStall) begin
          plus4 = m_pc + 32'd4;
          br_tk = inBranch && (inEq != inBne);
          if (inJump)     m_pc = (plus4 & 32'hF000_0000) | ({6'd0, inJumpIdx} * 32'd4);
          else if (br_tk) m_pc = plus4 + inImm * 32'd4;
          else            m_pc = plus4;
          m_taken = inJump || br_tk;
`ifdef BRANCH_STATS_EN
          if (inBranch) begin
            if (m_tot != 16'hFFFF) m_tot = m_tot + 16'd1;
            if (br_tk && m_tkn != 16'hFFFF) m_tkn = m_tkn + 16'd1;
          end
`endif
          m_mode = inHalt ? MD_HALTED : MD_FETCH;
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge inClk);
    model_step();
    @(negedge inClk);
  endtask

  task automatic clear_inputs();
    inFetchAck = 1'b0;
    inStall    = 1'b0;
    inHalt     = 1'b0;
    inBranch   = 1'b0;
    inBne      = 1'b0;
    inEq       = 1'b0;
    inJump     = 1'b0;
    inImm      = '0;
    inJumpIdx  = '0;
  endtask

  task automatic do_reset();
    inRstN = 1'b0;
    clear_inputs();
    repeat (2) @(negedge inClk);
    model_reset();
    inRstN = 1'b1;
  endtask

  // One full instruction: fetch with ack_dly cycles of wait, then COMMIT with
  // 'stalls' stalled cycles. Junk on decode lines outside COMMIT.
  task automatic run_instr(input int ack_dly, input int stalls,
                           input logic br, input logic bne, input logic eq,
                           input logic jmp, input logic [31:0] imm,
                           input logic [25:0] jidx, input logic halt);
    int   waited    = 0;
    int   stall_left = stalls;
    int   guard     = 0;
    int   prev;
    logic stalled;
    bit   done      = 0;
    while (!done && guard < 64) begin
      if (m_mode == MD_EXEC) begin
        inFetchAck = 1'($urandom);
        inBranch = br; inBne = bne; inEq = eq; inJump = jmp;
        inImm = imm; inJumpIdx = jidx; inHalt = halt;
        inStall = (stall_left > 0);
      end else begin
        inFetchAck = (m_mode == MD_FETCH) ? (waited >= ack_dly) : 1'($urandom);
        {inBranch, inBne, inEq, inJump, inHalt, inStall} = 6'($urandom);
        inImm = $urandom;
        inJumpIdx = 26'($urandom);
      end
      prev    = m_mode;
      stalled = inStall;
      if (m_mode == MD_FETCH) waited++;
      if (m_mode == MD_EXEC && stall_left > 0) stall_left--;
      cycle();
      guard++;
      checks++;
      if ({outPC, outPCPlus4, outFetchReq, outTaken, outHalted} !==
          {m_pc, m_pc + 32'd4, (m_mode == MD_FETCH), m_taken, (m_mode == MD_HALTED)}) begin
        errors++;
        $display("FAIL cycle_outputs: got pc=%h pc4=%h req=%b tk=%b hlt=%b exp pc=%h pc4=%h req=%b tk=%b hlt=%b",
                 outPC, outPCPlus4, outFetchReq, outTaken, outHalted,
                 m_pc, m_pc + 32'd4, (m_mode == MD_FETCH), m_taken, (m_mode == MD_HALTED));
      end
      if (prev == MD_EXEC && !stalled) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL instr_timeout: got no commit within %0d cycles, exp commit", guard);
    end
    clear_inputs();
  endtask

  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] off;
    off = (target - (m_pc + 32'd4)) >> 2;
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, off, 26'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({outPC, outFetchReq, outTaken, outHalted} !== {RESET_PC, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%h req=%b tk=%b hlt=%b exp pc=%h 0 0 0",
               outPC, outFetchReq, outTaken, outHalted, RESET_PC);
    end
    checks++;
    if ({outBrTotal, outBrTaken} !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: got %0d/%0d exp 0/0", outBrTotal, outBrTaken);
    end
    cycle();
    checks++;
    if (outFetchReq !== 1'b1 || outPC !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: got req=%b pc=%h exp req=1 pc=%h", outFetchReq, outPC, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0);
      exp_pc = 32'(i * 4);
      checks++;
      if (outPC !== exp_pc || outTaken !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc: got pc=%h tk=%b exp pc=%h tk=0", outPC, outTaken, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'h10, 1'b0);
    checks++;
    if (outPC !== 32'h40) begin
      errors++;
      $display("FAIL jump_to_40: got %h exp 00000040", outPC);
    end
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 26'd0, 1'b0);
    checks++;
    if (outPC !== 32'h50 || outTaken !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken: got pc=%h tk=%b exp pc=00000050 tk=1", outPC, outTaken);
    end
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'h10, 1'b0);
    run_instr(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 26'd0, 1'b0);
    checks++;
    if (outPC !== 32'h44 || outTaken !== 1'b0) begin
      errors++;
      $display("FAIL bne_not_taken: got pc=%h tk=%b exp pc=00000044 tk=0", outPC, outTaken);
    end
  endtask

  task automatic test_jump();
    goto_pc(32'h1000_0010);
    checks++;
    if (outPC !== 32'h1000_0010) begin
      errors++;
      $display("FAIL goto_10000010: got %h exp 10000010", outPC);
    end
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd7, 26'h10, 1'b0);
    checks++;
    if (outPC !== 32'h1000_0040 || outTaken !== 1'b1) begin
      errors++;
      $display("FAIL jump_wins: got pc=%h tk=%b exp pc=10000040 tk=1", outPC, outTaken);
    end
  endtask

  task automatic test_stall_ack();
    logic [31:0] start_pc;
    start_pc = m_pc;
    run_instr(5, 3, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 26'd0, 1'b0);
    checks++;
    if (outPC !== start_pc + 32'd12 || outTaken !== 1'b1) begin
      errors++;
      $display("FAIL stall_then_advance: got pc=%h tk=%b exp pc=%h tk=1", outPC, outTaken, start_pc + 32'd12);
    end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b0);
    checks++;
    if (outPC !== 32'h0 || outPCPlus4 !== 32'h4) begin
      errors++;
      $display("FAIL pc_wrap: got pc=%h pc4=%h exp pc=00000000 pc4=00000004", outPC, outPCPlus4);
    end
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd2, 1'b0);
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'd0, 1'b0);
    checks++;
    if (outPC !== 32'h8 || outTaken !== 1'b1) begin
      errors++;
      $display("FAIL neg_offset: got pc=%h tk=%b exp pc=00000008 tk=1", outPC, outTaken);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                $urandom, 26'($urandom), 1'b0);
    end
    checks++;
    if ({outBrTotal, outBrTaken} !== {m_tot, m_tkn}) begin
      errors++;
      $display("FAIL random_stats: got %0d/%0d exp %0d/%0d", outBrTotal, outBrTaken, m_tot, m_tkn);
    end
  endtask

  task automatic test_reset_mid_commit();
    int guard = 0;
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'h123, 1'b0);
    inFetchAck = 1'b1;
    while (m_mode != MD_EXEC && guard < 8) begin
      cycle();
      guard++;
    end
    inFetchAck = 1'b0;
    inStall = 1'b1; inJump = 1'b1; inJumpIdx = 26'h3FF;
    cycle();
    checks++;
    if (outPC === RESET_PC || m_mode != MD_EXEC) begin
      errors++;
      $display("FAIL pre_reset_state: got pc=%h mode=%0d exp pc!=%h mode=%0d", outPC, m_mode, RESET_PC, MD_EXEC);
    end
    #2;
    inRstN = 1'b0;
    #1;
    checks++;
    if ({outPC, outFetchReq, outTaken, outHalted} !== {RESET_PC, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got pc=%h req=%b tk=%b hlt=%b exp pc=%h 0 0 0",
               outPC, outFetchReq, outTaken, outHalted, RESET_PC);
    end
    inStall = 1'b0;
    @(posedge inClk);
    #1;
    checks++;
    if (outPC !== RESET_PC || outFetchReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got pc=%h req=%b exp pc=%h req=0", outPC, outFetchReq, RESET_PC);
    end
    do_reset();
    cycle();
  endtask

  task automatic test_stats();
    logic [STAT_W-1:0] exp_tot;
    logic [STAT_W-1:0] exp_tkn;
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 26'd0, 1'b0);
    run_instr(1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 26'd0, 1'b0);
    run_instr(0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 26'd0, 1'b0);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd5, 1'b0);
`ifdef BRANCH_STATS_EN
    exp_tot = 16'd3;
    exp_tkn = 16'd2;
`else
    exp_tot = 16'd0;
    exp_tkn = 16'd0;
`endif
    checks++;
    if (outBrTotal !== exp_tot || outBrTaken !== exp_tkn) begin
      errors++;
      $display("FAIL branch_stats: got %0d/%0d exp %0d/%0d", outBrTotal, outBrTaken, exp_tot, exp_tkn);
    end
  endtask

  task automatic test_halt();
    logic [31:0] held_pc;
    run_instr(0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 1'b1);
    held_pc = m_pc;
    checks++;
    if (outHalted !== 1'b1 || outFetchReq !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry: got hlt=%b req=%b exp hlt=1 req=0", outHalted, outFetchReq);
    end
    for (int i = 0; i < 10; i++) begin
      inFetchAck = 1'b1;
      {inBranch, inBne, inEq, inJump} = 4'($urandom);
      inImm = $urandom;
      cycle();
      checks++;
      if ({outPC, outFetchReq, outTaken, outHalted} !== {held_pc, 3'b001}) begin
        errors++;
        $display("FAIL halt_hold: got pc=%h req=%b tk=%b hlt=%b exp pc=%h 0 0 1",
                 outPC, outFetchReq, outTaken, outHalted, held_pc);
      end
    end
    clear_inputs();
  endtask

  initial begin
    inRstN = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_ack();
    test_wrap();
    test_random();
    test_reset_mid_commit();
    test_stats();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish by 1ms, exp finish");
    $fatal(1, "timeout");
  end

endmodule
